// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: core and program-loader request ports plus the memory port.
// slave is the arbiter's view, master is the environment's view (requesters and memory).
interface mem_bus_arbiter_if #(
    parameter int unsigned AW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [31:0]   core_wdata;
    logic [31:0]   core_rdata;
    logic          core_ready;

    logic          ldr_req;
    logic          ldr_we;
    logic [AW-1:0] ldr_addr;
    logic [31:0]   ldr_wdata;
    logic [31:0]   ldr_rdata;
    logic          ldr_ready;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_rdata, core_ready,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_rdata, core_ready,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port (core / program loader) arbiter onto one fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the loader has fixed priority.
module mem_bus_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned AW      = 32
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e        state;
    logic [3:0]    cnt;
    logic          grant_ldr;
`ifdef ARB_ROUND_ROBIN_EN
    logic          last_grant_ldr;
`endif

    logic          pick_ldr;
    logic          pick_we;
    logic [AW-1:0] pick_addr;
    logic [31:0]   pick_wdata;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie the port that did not win last time is served.
        pick_ldr = bus.ldr_req && (!bus.core_req || !last_grant_ldr);
`else
        pick_ldr = bus.ldr_req;
`endif
        pick_we    = pick_ldr ? bus.ldr_we    : bus.core_we;
        pick_addr  = pick_ldr ? bus.ldr_addr  : bus.core_addr;
        pick_wdata = pick_ldr ? bus.ldr_wdata : bus.core_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= StIdle;
            cnt            <= '0;
            grant_ldr      <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.core_ready <= 1'b0;
            bus.ldr_ready  <= 1'b0;
            bus.core_rdata <= '0;
            bus.ldr_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_ldr <= 1'b1;
`endif
        end else begin
            bus.core_ready <= 1'b0;
            bus.ldr_ready  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (bus.core_req || bus.ldr_req) begin
                        grant_ldr     <= pick_ldr;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= pick_we;
                        bus.mem_addr  <= pick_addr;
                        bus.mem_wdata <= pick_wdata;
                        cnt           <= 4'(MEM_LAT - 1);
                        state         <= StBusy;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_ldr <= pick_ldr;
`endif
                    end
                end
                StBusy: begin
                    if (cnt == '0) begin
                        bus.mem_en <= 1'b0;
                        state      <= StDone;
                        if (grant_ldr) begin
                            bus.ldr_ready <= 1'b1;
                        end else begin
                            bus.core_ready <= 1'b1;
                        end
                        // Writes leave the winner's read-data register untouched.
                        if (!bus.mem_we) begin
                            if (grant_ldr) begin
                                bus.ldr_rdata <= bus.mem_rdata;
                            end else begin
                                bus.core_rdata <= bus.mem_rdata;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: two arbiters (MEM_LAT=2 and MEM_LAT=1) share one stimulus stream; a transaction
// model predicts grants and completion cycles, a monitor checks every cycle of both.
module tb_mem_bus_arbiter;
    localparam int unsigned AW = 32;

    typedef struct packed {
        logic        en;
        logic        we;
        logic        crdy;
        logic        lrdy;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] crd;
        logic [31:0] lrd;
    } out_t;

    typedef struct {
        bit          ldr;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          edge_n;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_bus_arbiter_if #(.AW(AW)) bus0 ();
    mem_bus_arbiter_if #(.AW(AW)) bus1 ();

    mem_bus_arbiter #(.MEM_LAT(2), .AW(AW)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mem_bus_arbiter #(.MEM_LAT(1), .AW(AW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    out_t o [2];
    assign o[0] = {bus0.mem_en, bus0.mem_we, bus0.core_ready, bus0.ldr_ready,
                   bus0.mem_addr, bus0.mem_wdata, bus0.core_rdata, bus0.ldr_rdata};
    assign o[1] = {bus1.mem_en, bus1.mem_we, bus1.core_ready, bus1.ldr_ready,
                   bus1.mem_addr, bus1.mem_wdata, bus1.core_rdata, bus1.ldr_rdata};

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    txn_t        q [2][$];
    int          free_e [2];
    bit          lg_ldr [2];
    logic [31:0] rd_m [2][2];
    logic [31:0] shown [2][2];
    logic [31:0] mm [2][16];
    logic [31:0] marr [2][16];
    int          run [2];
    bit          seen0 [$];
    bit          g_hit;
    bit          g_ldr;
    int          g_done;

    function automatic int lat(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Memory behind each DUT: data appears only in the MEM_LAT-th cycle of mem_en.
    initial begin
        run[0] = 0;
        run[1] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic [31:0] v;
                if (o[d].en === 1'b1) run[d]++;
                else run[d] = 0;
                v = $urandom;
                if (o[d].en === 1'b1 && run[d] == lat(d)) begin
                    if (o[d].we) marr[d][o[d].addr[5:2]] = o[d].wdata;
                    else v = marr[d][o[d].addr[5:2]];
                end
                if (d == 0) bus0.mem_rdata = v;
                else bus1.mem_rdata = v;
            end
        end
    end

    task automatic mon(int d);
        out_t s;
        txn_t t;
        bit   has, en_e, rdy_e;
        int   l;
        s   = o[d];
        l   = lat(d);
        has = q[d].size() > 0;
        if (has) t = q[d][0];
        en_e  = has && cyc >= t.edge_n && cyc < t.edge_n + l;
        rdy_e = has && cyc == t.edge_n + l;
        chk($sformatf("d%0d mem_en", d), 32'(s.en), 32'(en_e));
        chk($sformatf("d%0d core_ready", d), 32'(s.crdy), 32'(rdy_e && !t.ldr));
        chk($sformatf("d%0d ldr_ready", d), 32'(s.lrdy), 32'(rdy_e && t.ldr));
        if (en_e) begin
            chk($sformatf("d%0d mem_we", d), 32'(s.we), 32'(t.we));
            chk($sformatf("d%0d mem_addr", d), s.addr, t.addr);
            chk($sformatf("d%0d mem_wdata", d), s.wdata, t.wdata);
        end
        if (rst_q) begin
            chk($sformatf("d%0d reset mem_we", d), 32'(s.we), 32'd0);
            chk($sformatf("d%0d reset mem_addr", d), s.addr, 32'd0);
            chk($sformatf("d%0d reset mem_wdata", d), s.wdata, 32'd0);
        end
        if (d == 0 && s.crdy === 1'b1) seen0.push_back(1'b0);
        if (d == 0 && s.lrdy === 1'b1) seen0.push_back(1'b1);
        if (rdy_e) begin
            void'(q[d].pop_front());
            shown[d][t.ldr] = t.rdata;
        end
        chk($sformatf("d%0d core_rdata", d), s.crd, shown[d][0]);
        chk($sformatf("d%0d ldr_rdata", d), s.lrd, shown[d][1]);
    endtask

    initial begin
        @(negedge clk);
        forever begin
            for (int d = 0; d < 2; d++) mon(d);
            @(negedge clk);
        end
    end

    // Drive inputs for the coming edge, predict what both arbiters do at it, then advance a cycle.
    task automatic step(bit cr, bit cw, logic [31:0] ca, logic [31:0] cd,
                        bit lr, bit lw, logic [31:0] la, logic [31:0] ld, bit r);
        int e;
        e = cyc + 1;
        rst = r;
        bus0.core_req = cr; bus0.core_we = cw; bus0.core_addr = ca; bus0.core_wdata = cd;
        bus0.ldr_req  = lr; bus0.ldr_we  = lw; bus0.ldr_addr  = la; bus0.ldr_wdata  = ld;
        bus1.core_req = cr; bus1.core_we = cw; bus1.core_addr = ca; bus1.core_wdata = cd;
        bus1.ldr_req  = lr; bus1.ldr_we  = lw; bus1.ldr_addr  = la; bus1.ldr_wdata  = ld;
        g_hit = 1'b0;
        for (int d = 0; d < 2; d++) begin
            txn_t t;
            bit   wl;
            if (r) begin
                q[d].delete();
                free_e[d] = e + 1;
                lg_ldr[d] = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    rd_m[d][p]  = '0;
                    shown[d][p] = '0;
                end
            end else if (e >= free_e[d] && (cr || lr)) begin
`ifdef ARB_ROUND_ROBIN_EN
                wl = lr && (!cr || !lg_ldr[d]);
`else
                wl = lr;
`endif
                lg_ldr[d] = wl;
                t.ldr    = wl;
                t.we     = wl ? lw : cw;
                t.addr   = wl ? la : ca;
                t.wdata  = wl ? ld : cd;
                t.edge_n = e;
                if (t.we) begin
                    mm[d][t.addr[5:2]] = t.wdata;
                    t.rdata = rd_m[d][wl];
                end else begin
                    t.rdata = mm[d][t.addr[5:2]];
                end
                rd_m[d][wl] = t.rdata;
                q[d].push_back(t);
                // Busy for MEM_LAT cycles, one DONE cycle, one IDLE cycle before the next grant.
                free_e[d] = e + lat(d) + 2;
                if (d == 0) begin
                    g_hit  = 1'b1;
                    g_ldr  = wl;
                    g_done = e + lat(d);
                end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(int n, bit r);
        repeat (n) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, r);
    endtask

    int          st [2];
    int          de [2];
    bit          rq [2];
    bit          wq [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  exp_pat;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                mm[d][i]   = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101);
                marr[d][i] = mm[d][i];
            end
            mm[d][4]   = 32'hDEAD_BEEF;
            marr[d][4] = 32'hDEAD_BEEF;
        end
        idle(2, 1'b1);

        // Core read of 0x10.
        repeat (3) step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idle(2, 1'b0);
        chk("core read data", bus0.core_rdata, 32'hDEAD_BEEF);

        // Loader write must not disturb ldr_rdata.
        repeat (3) step(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 32'h1234_5678, 0);
        idle(2, 1'b0);
        chk("ldr_rdata after write", bus0.ldr_rdata, 32'h0);

        // Both ports requesting continuously after reset.
        idle(1, 1'b1);
        seen0.delete();
        repeat (16) step(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0, 0);
        idle(2, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        exp_pat = 4'b1010;
`else
        exp_pat = 4'b1111;
`endif
        chk("contention grant count", 32'(seen0.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen0.size(); i++)
            chk($sformatf("contention grant %0d is loader", i), 32'(seen0[i]), 32'(exp_pat[i]));

        // Reset during the second busy cycle aborts the access; a later request is served.
        idle(1, 1'b1);
        seen0.delete();
        repeat (2) step(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        step(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        idle(3, 1'b0);
        chk("aborted access ready count", 32'(seen0.size()), 32'd0);
        repeat (3) step(1, 0, 32'h34, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idle(2, 1'b0);
        chk("post-abort ready count", 32'(seen0.size()), 32'd1);

        // Request dropped right after the grant still completes.
        idle(1, 1'b1);
        seen0.delete();
        step(1, 0, 32'h38, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        idle(4, 1'b0);
        chk("dropped req ready count", 32'(seen0.size()), 32'd1);

        // Randomized traffic; requesters follow the hold-until-ready protocol of the MEM_LAT=2 unit.
        for (int p = 0; p < 2; p++) begin
            st[p] = 0;
            rq[p] = 1'b0;
        end
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (st[p] == 2 && cyc >= de[p]) begin
                    st[p] = 0;
                    rq[p] = 1'b0;
                end else if (st[p] == 2 && $urandom_range(0, 4) == 0) begin
                    rq[p] = 1'b0;
                end
                if (st[p] == 0 && $urandom_range(0, 2) == 0) begin
                    st[p] = 1;
                    rq[p] = 1'b1;
                    wq[p] = 1'($urandom_range(0, 1));
                    ad[p] = $urandom;
                    wd[p] = $urandom;
                end
                if (!rq[p]) begin
                    wq[p] = 1'($urandom_range(0, 1));
                    ad[p] = $urandom;
                    wd[p] = $urandom;
                end
            end
            step(rq[0], wq[0], ad[0], wd[0], rq[1], wq[1], ad[1], wd[1], 0);
            if (g_hit) begin
                st[g_ldr] = 2;
                de[g_ldr] = g_done;
            end
        end
        idle(20, 1'b0);
        chk("d0 outstanding transactions", 32'(q[0].size()), 32'd0);
        chk("d1 outstanding transactions", 32'(q[1].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
